// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, Booth triplet encodings and group-count helper
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] BT_ZERO_P = 3'b000;
    localparam logic [2:0] BT_P1_A   = 3'b001;
    localparam logic [2:0] BT_P1_B   = 3'b010;
    localparam logic [2:0] BT_P2     = 3'b011;
    localparam logic [2:0] BT_M2     = 3'b100;
    localparam logic [2:0] BT_M1_A   = 3'b101;
    localparam logic [2:0] BT_M1_B   = 3'b110;
    localparam logic [2:0] BT_ZERO_N = 3'b111;

    // One extra group covers the two extension bits, so unsigned operands stay exact.
    function automatic int ng(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// rtl/booth_r4_pp_sel.sv - radix-4 Booth partial-product selector (0, +-A, +-2A)
module booth_r4_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]              triplet,
    input  logic [WIDTH+1:0]        a_ext,
    output logic signed [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] a_one;
    logic [WIDTH+2:0] a_two;

    assign a_one = {a_ext[WIDTH+1], a_ext};
    assign a_two = {a_ext, 1'b0};

    always_comb begin
        pp = '0;
        case (triplet)
            BT_P1_A, BT_P1_B: pp = a_one;
            BT_P2:            pp = a_two;
            BT_M2:            pp = -a_two;
            BT_M1_A, BT_M1_B: pp = -a_one;
            default:          pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_mul_seq.sv
// rtl/booth_radix4_mul_seq.sv - sequential radix-4 Booth multiplier, one group per clock
module booth_radix4_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int AW   = WIDTH + 2;
    localparam int BW   = WIDTH + 3;
    localparam int PW   = WIDTH + 3;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int NG   = ng(WIDTH);
    localparam int CW   = $clog2(NG + 1);
    localparam logic [CW-1:0] LAST = CW'(NG - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_mul_seq: WIDTH must be even and >= 4");
    end

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       a_ext;
    logic [BW-1:0]       b_ext;
    logic [ACCW-1:0]     acc;
    logic [ACCW-1:0]     acc_next;
    logic [ACCW-1:0]     pp_ext;
    logic [CW-1:0]       count;
    logic                zero_op;
    logic                accept;
    logic                finish;
    logic signed [PW-1:0] pp;

    booth_r4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .triplet (b_ext[2:0]),
        .a_ext   (a_ext),
        .pp      (pp)
    );

    assign pp_ext   = {{(ACCW - PW){pp[PW-1]}}, pp};
    assign acc_next = acc + (pp_ext << {count, 1'b0});

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (zero_op || count == LAST) begin
                    finish     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Extension width absorbs the signedness flags, so they need no register of their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_ext   <= '0;
            b_ext   <= '0;
            acc     <= '0;
            count   <= '0;
            zero_op <= 1'b0;
            product <= '0;
        end else if (accept) begin
            a_ext   <= a_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            b_ext   <= {(b_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b}), 1'b0};
            acc     <= '0;
            count   <= '0;
            zero_op <= ZERO_SKIP && ((a == '0) || (b == '0));
        end else if (state == CALC) begin
            acc   <= acc_next;
            b_ext <= {{2{b_ext[BW-1]}}, b_ext[BW-1:2]};
            count <= count + 1'b1;
            if (finish) begin
                product <= zero_op ? '0 : acc_next[2*WIDTH-1:0];
            end
        end
    end

endmodule
